// File: rtl/pixel_scheduler_pkg.sv
// Shared types and constants for the pixel scheduler and its downstream pixel sink.
package pixel_scheduler_pkg;

    // Fixed-point coordinate format (signed Q16.16).
    localparam int FP_W    = 32;
    localparam int FP_FRAC = 16;
    typedef logic signed [FP_W-1:0] fp;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Plain-vector aliases of the states for the state register.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    // Pixel tag as seen by the pixel sink; wide enough for any supported resolution.
    localparam int TAG_W = 16;
    typedef struct packed {
        logic [TAG_W-1:0] x;
        logic [TAG_W-1:0] y;
        logic             sof;
        logic             eol;
    } pixel_tag_t;

endpackage

// File: rtl/pixel_scheduler_if.sv
// Bundle of configuration, credit-return and issue signals around the pixel scheduler.
interface pixel_scheduler_if
    import pixel_scheduler_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          start;
    fp             x_start;
    fp             y_start;
    fp             x_step;
    fp             y_step;
    logic          ret_valid;
    logic          valid_out;
    fp             screen_x;
    fp             screen_y;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          sof;
    logic          eol;
    logic          busy;
    logic          frame_done;
    logic          cred_err;

    // Environment side: drives config and returns, observes issued pixels.
    modport master (
        output start, x_start, y_start, x_step, y_step, ret_valid,
        input  valid_out, screen_x, screen_y, pixel_x, pixel_y,
        input  sof, eol, busy, frame_done, cred_err
    );

    // Scheduler side.
    modport slave (
        input  start, x_start, y_start, x_step, y_step, ret_valid,
        output valid_out, screen_x, screen_y, pixel_x, pixel_y,
        output sof, eol, busy, frame_done, cred_err
    );
endinterface

// File: rtl/pixel_scheduler_credit_counter.sv
// Credit counter bounding the number of rays in flight; saturates at DEPTH (DEPTH >= 1).
module credit_counter #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic take,
    input  logic give,
    output logic avail,
    output logic full,
    output logic err
);
    localparam int            CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [CW-1:0] r_count;
    logic          r_err;

    assign avail = (r_count != '0);
    assign full  = (r_count == C_MAX);
    assign err   = r_err;

    // count: -take +give; a return at full saturates and raises the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= C_MAX;
            r_err   <= 1'b0;
        end else if (take && !give) begin
            if (r_count != '0) begin
                r_count <= r_count - C_ONE;
            end
        end else if (give && !take) begin
            if (full) begin
                r_err <= 1'b1;
            end else begin
                r_count <= r_count + C_ONE;
            end
        end
    end
endmodule

// File: rtl/pixel_scheduler.sv
// Raster-order pixel issuer feeding ray_unit, throttled by returned credits.
module pixel_scheduler
    import pixel_scheduler_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pixel_scheduler_if.slave  bus
);
    localparam int            XW     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int            YW     = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_busy;
    logic          r_done;
    fp             r_x_start;
    fp             r_x_step;
    fp             r_y_step;
    fp             r_cur_x;
    fp             r_cur_y;
    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic          r_valid;
    fp             r_sx;
    fp             r_sy;
    logic [XW-1:0] r_px;
    logic [YW-1:0] r_py;
    logic          r_sof;
    logic          r_eol;

    logic w_avail;
    logic w_full;
    logic w_err;
    logic w_issue;
    logic w_start_ok;
    logic w_row_end;
    logic w_last_pix;

    // Issue decision uses only the registered credit count.
    assign w_issue    = (r_state == ST_RUN) && w_avail;
    assign w_start_ok = (r_state == ST_IDLE) && bus.start;
    assign w_row_end  = (r_col == X_LAST);
    assign w_last_pix = w_row_end && (r_row == Y_LAST);

    // Credits are always back at the maximum whenever the FSM is idle, so start needs no reload.
    credit_counter #(.DEPTH(MAX_INFLIGHT)) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .take  (w_issue),
        .give  (bus.ret_valid),
        .avail (w_avail),
        .full  (w_full),
        .err   (w_err)
    );

    // Next-state decode for IDLE -> RUN -> DRAIN -> DONE -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start)              w_state_next = ST_RUN;
            ST_RUN:   if (w_issue && w_last_pix)  w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_full)                 w_state_next = ST_DONE;
            ST_DONE:                              w_state_next = ST_IDLE;
            default:                              w_state_next = ST_IDLE;
        endcase
    end

    // State register plus busy/frame_done flops derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Frame configuration captured only on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_start <= '0;
            r_x_step  <= '0;
            r_y_step  <= '0;
        end else if (w_start_ok) begin
            r_x_start <= bus.x_start;
            r_x_step  <= bus.x_step;
            r_y_step  <= bus.y_step;
        end
    end

    // Raster counters and incrementally stepped coordinates (wrapping adds)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else if (w_start_ok) begin
            r_col   <= '0;
            r_row   <= '0;
            r_cur_x <= bus.x_start;
            r_cur_y <= bus.y_start;
        end else if (w_issue) begin
            if (w_row_end) begin
                r_col   <= '0;
                r_row   <= r_row + Y_ONE;
                r_cur_x <= r_x_start;
                r_cur_y <= r_cur_y + r_y_step;
            end else begin
                r_col   <= r_col + X_ONE;
                r_cur_x <= r_cur_x + r_x_step;
            end
        end
    end

    // Output flops: strobe every cycle, payload held between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_sx  <= r_cur_x;
                r_sy  <= r_cur_y;
                r_px  <= r_col;
                r_py  <= r_row;
                r_sof <= (r_col == '0) && (r_row == '0);
                r_eol <= w_row_end;
            end
        end
    end

    assign bus.valid_out  = r_valid;
    assign bus.screen_x   = r_sx;
    assign bus.screen_y   = r_sy;
    assign bus.pixel_x    = r_px;
    assign bus.pixel_y    = r_py;
    assign bus.sof        = r_sof;
    assign bus.eol        = r_eol;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.cred_err   = w_err;
endmodule
